// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: decode handshake, execute redirect and instruction-memory port.
// master = fetch_pc_unit, slave = decode/execute/memory environment.
interface fetch_pc_unit_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        imem_err;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] incPC;
    logic        instr_valid;
    logic        halted;
    logic        err;

    modport master (
        input  stall, redirect, redirect_pc, halt, imem_done, imem_data, imem_err,
        output imem_rd, imem_addr, instr, pc, incPC, instr_valid, halted, err
    );

    modport slave (
        output stall, redirect, redirect_pc, halt, imem_done, imem_data, imem_err,
        input  imem_rd, imem_addr, instr, pc, incPC, instr_valid, halted, err
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// WISC-F24 fetch front end: owns the PC, issues single outstanding word reads,
// presents instructions to decode and squashes in-flight reads on redirect.
//
// state    | meaning
// S_FETCH  | read strobe issued at pc this cycle
// S_WAIT   | read outstanding, waiting for imem_done (squash drops the data)
// S_HOLD   | instruction presented to decode, held while stall
// S_HALTED | stopped on HALT or error, exits only via rst
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_unit_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic        valid_q;
    logic        halted_q;
    logic        err_q;
    logic        squash_q;
    logic [15:0] inc_pc;

    assign inc_pc = pc_q + 16'd2;

    // A redirect in FETCH retargets pc before the strobe leaves the block.
    assign bus.imem_rd     = (state == S_FETCH) && !bus.redirect && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.incPC       = inc_pc;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            squash_q <= 1'b0;
        end else if (bus.redirect && state != S_HALTED) begin
            pc_q    <= bus.redirect_pc;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (state == S_WAIT && bus.imem_done && bus.imem_err)
                err_q <= 1'b1;
            if (bus.redirect_pc[0]) begin
                err_q    <= 1'b1;
                halted_q <= 1'b1;
                squash_q <= 1'b0;
                state    <= S_HALTED;
            end else begin
                unique case (state)
                    S_WAIT: begin
                        // The old read must drain before a new one may issue.
                        if (bus.imem_done) begin
                            squash_q <= 1'b0;
                            state    <= S_FETCH;
                        end else begin
                            squash_q <= 1'b1;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end else begin
            unique case (state)
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.imem_done) begin
                        if (squash_q) begin
                            squash_q <= 1'b0;
                            state    <= S_FETCH;
                        end else if (bus.imem_err) begin
                            err_q    <= 1'b1;
                            halted_q <= 1'b1;
                            state    <= S_HALTED;
                        end else begin
                            instr_q <= bus.imem_data;
                            valid_q <= 1'b1;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (bus.halt) begin
                            halted_q <= 1'b1;
                            state    <= S_HALTED;
                        end else begin
                            pc_q  <= inc_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a variable-latency instruction memory model.
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   lat = 1;
    int   mcnt = 0;
    logic [15:0] maddr = 16'h0;
    logic        err_en = 1'b0;
    logic [15:0] err_addr = 16'h0;
    logic        found;
    int          rds, vals;

    fetch_pc_unit_if bus ();

    fetch_pc_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: strobe seen at negedge of cycle N, done during cycle N+lat.
    always @(negedge clk) begin
        bus.imem_done = 1'b0;
        bus.imem_err  = 1'b0;
        if (rst) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.imem_done = 1'b1;
                    bus.imem_data = mdata(maddr);
                    bus.imem_err  = err_en && (maddr == err_addr);
                end
            end
            if (bus.imem_rd) begin
                mcnt  = lat;
                maddr = bus.imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (bus.imem_rd) ok = 1'b1;
            else nxt();
        end
    endtask

    task automatic wait_valid(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (bus.instr_valid) ok = 1'b1;
            else nxt();
        end
    endtask

    task automatic quiet(input int n, output int r, output int v);
        r = 0;
        v = 0;
        for (int i = 0; i < n; i++) begin
            nxt();
            r += int'(bus.imem_rd);
            v += int'(bus.instr_valid);
        end
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.halt        = 1'b0;
        bus.imem_done   = 1'b0;
        bus.imem_data   = 16'h0;
        bus.imem_err    = 1'b0;

        // reset state
        nxt();
        nxt();
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_incpc", bus.incPC, 16'h0002);
        check("rst_instr", bus.instr, 16'h0800);
        check("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
        check("rst_rd", {15'd0, bus.imem_rd}, 16'd0);
        check("rst_halted", {15'd0, bus.halted}, 16'd0);
        check("rst_err", {15'd0, bus.err}, 16'd0);

        // latency 1 streaming: rd every 3 cycles, valid 2 cycles after rd
        rst = 1'b0;
        #1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) nxt();
            check("t1_rd", {15'd0, bus.imem_rd}, {15'd0, (k % 3 == 0)});
            check("t1_valid", {15'd0, bus.instr_valid}, {15'd0, (k % 3 == 2)});
            if (k % 3 == 0) check("t1_addr", bus.imem_addr, 16'(2 * (k / 3)));
            if (k % 3 == 2) begin
                check("t1_pc", bus.pc, 16'(2 * (k / 3)));
                check("t1_incpc", bus.incPC, 16'(2 * (k / 3) + 2));
                check("t1_instr", bus.instr, mdata(16'(2 * (k / 3))));
            end else begin
                check("t1_nop", bus.instr, 16'h0800);
            end
        end

        // stall hold for 5 cycles on the word at 6
        nxt();
        check("t3_rd", {15'd0, bus.imem_rd}, 16'd1);
        check("t3_addr", bus.imem_addr, 16'h0006);
        bus.stall = 1'b1;
        nxt();
        nxt();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            check("t3_valid", {15'd0, bus.instr_valid}, 16'd1);
            check("t3_pc", bus.pc, 16'h0006);
            check("t3_incpc", bus.incPC, 16'h0008);
            check("t3_instr", bus.instr, mdata(16'h0006));
            check("t3_nord", {15'd0, bus.imem_rd}, 16'd0);
        end
        bus.stall = 1'b0;
        lat = 4;
        nxt();
        check("t3_next_rd", {15'd0, bus.imem_rd}, 16'd1);
        check("t3_next_addr", bus.imem_addr, 16'h0008);

        // latency 4, redirect during the second WAIT cycle
        nxt();
        nxt();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        nxt();
        bus.redirect = 1'b0;
        check("t2_pc", bus.pc, 16'h0040);
        check("t2_rd_a", {15'd0, bus.imem_rd}, 16'd0);
        check("t2_valid_a", {15'd0, bus.instr_valid}, 16'd0);
        nxt();
        check("t2_rd_b", {15'd0, bus.imem_rd}, 16'd0);
        check("t2_valid_b", {15'd0, bus.instr_valid}, 16'd0);
        nxt();
        check("t2_rd", {15'd0, bus.imem_rd}, 16'd1);
        check("t2_addr", bus.imem_addr, 16'h0040);
        wait_valid(12, found);
        check("t2_valid_seen", {15'd0, found}, 16'd1);
        check("t2_vpc", bus.pc, 16'h0040);
        check("t2_vinstr", bus.instr, mdata(16'h0040));
        check("t2_vincpc", bus.incPC, 16'h0042);

        // consume with halt
        bus.halt = 1'b1;
        nxt();
        bus.halt = 1'b0;
        check("t4_halted", {15'd0, bus.halted}, 16'd1);
        check("t4_valid", {15'd0, bus.instr_valid}, 16'd0);
        check("t4_instr", bus.instr, 16'h0800);
        quiet(20, rds, vals);
        check("t4_no_rd", 16'(rds), 16'd0);
        check("t4_no_valid", 16'(vals), 16'd0);
        check("t4_still_halted", {15'd0, bus.halted}, 16'd1);
        check("t4_pc_frozen", bus.pc, 16'h0040);
        rst = 1'b1;
        nxt();
        check("t4_rst_pc", bus.pc, 16'h0000);
        check("t4_rst_halted", {15'd0, bus.halted}, 16'd0);
        lat = 1;
        rst = 1'b0;
        #1;
        check("t4_restart_rd", {15'd0, bus.imem_rd}, 16'd1);
        check("t4_restart_addr", bus.imem_addr, 16'h0000);

        // redirect in FETCH to 16'hFFFE, then wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        #1;
        check("t5_rd_gated", {15'd0, bus.imem_rd}, 16'd0);
        nxt();
        bus.redirect = 1'b0;
        #1;
        check("t5_rd", {15'd0, bus.imem_rd}, 16'd1);
        check("t5_addr", bus.imem_addr, 16'hFFFE);
        check("t5_incpc", bus.incPC, 16'h0000);
        wait_valid(8, found);
        check("t5_valid_seen", {15'd0, found}, 16'd1);
        check("t5_vpc", bus.pc, 16'hFFFE);
        check("t5_vincpc", bus.incPC, 16'h0000);
        check("t5_vinstr", bus.instr, mdata(16'hFFFE));
        nxt();
        wait_rd(8, found);
        check("t5_rd_seen", {15'd0, found}, 16'd1);
        check("t5_wrap_addr", bus.imem_addr, 16'h0000);

        // misaligned redirect
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0013;
        #1;
        check("t6_rd_gated", {15'd0, bus.imem_rd}, 16'd0);
        nxt();
        bus.redirect = 1'b0;
        check("t6_err", {15'd0, bus.err}, 16'd1);
        check("t6_halted", {15'd0, bus.halted}, 16'd1);
        check("t6_valid", {15'd0, bus.instr_valid}, 16'd0);
        quiet(5, rds, vals);
        check("t6_no_rd", 16'(rds), 16'd0);

        // memory error on the first fetch
        rst = 1'b1;
        nxt();
        check("t6_rst_err", {15'd0, bus.err}, 16'd0);
        err_en   = 1'b1;
        err_addr = 16'h0000;
        rst = 1'b0;
        quiet(6, rds, vals);
        check("t6m_no_valid", 16'(vals), 16'd0);
        check("t6m_err", {15'd0, bus.err}, 16'd1);
        check("t6m_halted", {15'd0, bus.halted}, 16'd1);
        check("t6m_instr", bus.instr, 16'h0800);
        err_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
